// File: rtl/read_out_sequencer_if.sv
// Bundle of trigger, result-memory read port and output stream for read_out_sequencer.
// The sequencer connects through the master modport; the environment connects through slave.
interface read_out_sequencer_if #(
    parameter int D_WIDTH    = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BANK_W     = 2
);
    logic                  output_trigger_in;
    logic                  res_rd_en_out;
    logic [ADDR_WIDTH-1:0] res_rd_addr_out;
    logic [BANK_W-1:0]     res_rd_bank_out;
    logic [D_WIDTH-1:0]    res_rd_data_in;
    logic [D_WIDTH-1:0]    out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic                  busy_out;
    logic                  done_out;
    logic                  overrun_out;

    modport master (
        input  output_trigger_in,
        input  res_rd_data_in,
        input  out_ready,
        output res_rd_en_out,
        output res_rd_addr_out,
        output res_rd_bank_out,
        output out_data,
        output out_valid,
        output out_last,
        output busy_out,
        output done_out,
        output overrun_out
    );

    modport slave (
        output output_trigger_in,
        output res_rd_data_in,
        output out_ready,
        input  res_rd_en_out,
        input  res_rd_addr_out,
        input  res_rd_bank_out,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  busy_out,
        input  done_out,
        input  overrun_out
    );
endinterface

// File: rtl/read_out_sequencer.sv
// read_out_sequencer: on each toggle of output_trigger_in, reads BURST_LEN words from each of
// NUM_BANKS result banks (bank-major order) and streams them out through a small FIFO with
// valid/ready flow control. Reads are throttled so returning data always has a FIFO slot.
// Optional feature macro READ_OUT_SEQ_PENDING_EN: hold one trigger arriving while busy and
// start it after the current job; without it, such triggers are dropped and flagged.
module read_out_sequencer #(
    parameter int D_WIDTH    = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int BURST_LEN  = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    read_out_sequencer_if.master io_bus
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(BURST_LEN - 1);
    localparam logic [BANK_W-1:0]     BANK_LAST = BANK_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]      LEVEL_MAX = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_trig;
    logic                  r_armed;
    logic                  w_edge;
    logic                  w_start;
    logic                  w_busy;
    logic                  r_overrun;
    logic                  r_done;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BANK_W-1:0]     r_bank;
    logic                  w_issue;
    logic                  w_issue_last;

    logic [RD_LATENCY-1:0] r_rd_vld;
    logic [RD_LATENCY-1:0] r_rd_last;
    logic [CNT_W-1:0]      w_inflight;
    logic [CNT_W-1:0]      w_level;

    logic [D_WIDTH-1:0]    r_mem_data [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fifo_cnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_out_valid;
    logic                  w_out_last;

    // Circular pointer advance; FIFO_DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Trigger copy follows the input every cycle, including while reset is held,
    // so the level present at release is never mistaken for a request.
    always_ff @(posedge clk) begin
        r_trig <= io_bus.output_trigger_in;
    end

    // Edge detection is disarmed for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    assign w_edge = r_armed & (io_bus.output_trigger_in ^ r_trig);
    assign w_busy = (r_state != S_IDLE);

`ifdef READ_OUT_SEQ_PENDING_EN
    logic r_pending;

    // One request may wait while busy; a second while one waits is lost and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_edge && r_pending) begin
                r_overrun <= 1'b1;
            end
            if (!w_busy) begin
                r_pending <= 1'b0;
            end else if (w_edge) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_start = w_edge | r_pending;
`else
    // Any request arriving while a job runs is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_edge && w_busy) begin
            r_overrun <= 1'b1;
        end
    end

    assign w_start = w_edge;
`endif

    // Count reads whose data has not yet been written into the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_rd_vld[i]);
        end
        w_level = r_fifo_cnt + w_inflight;
    end

    // A read is only launched when its data is guaranteed a FIFO slot on return.
    assign w_issue      = (r_state == S_READ) && (w_level < LEVEL_MAX);
    assign w_issue_last = (r_bank == BANK_LAST) && (r_addr == ADDR_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: start on request, drain after the last strobe, finish on last accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_issue && w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_out_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address/bank walk; both wrap to zero after the final word so the next job starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_bank <= '0;
        end else if (w_issue) begin
            if (r_addr == ADDR_LAST) begin
                r_addr <= '0;
                r_bank <= (r_bank == BANK_LAST) ? '0 : r_bank + 1'b1;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Read-latency tracker: a strobe's tag reaches the last stage when its data is on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld  <= '0;
            r_rd_last <= '0;
        end else begin
            r_rd_vld[0]  <= w_issue;
            r_rd_last[0] <= w_issue & w_issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_vld[i]  <= r_rd_vld[i-1];
                r_rd_last[i] <= r_rd_last[i-1];
            end
        end
    end

    assign w_push      = r_rd_vld[RD_LATENCY-1];
    assign w_out_valid = (r_fifo_cnt != '0);
    assign w_pop       = w_out_valid & io_bus.out_ready;

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are only observable through a valid entry, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= io_bus.res_rd_data_in;
            r_mem_last[r_wr_ptr] <= r_rd_last[RD_LATENCY-1];
        end
    end

    assign w_out_last = w_out_valid & r_mem_last[r_rd_ptr];

    // Job-complete pulse, one cycle after the final word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_pop && w_out_last;
        end
    end

    assign io_bus.res_rd_en_out   = w_issue;
    assign io_bus.res_rd_addr_out = r_addr;
    assign io_bus.res_rd_bank_out = r_bank;
    assign io_bus.out_valid       = w_out_valid;
    assign io_bus.out_data        = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign io_bus.out_last        = w_out_last;
    assign io_bus.busy_out        = w_busy;
    assign io_bus.done_out        = r_done;
    assign io_bus.overrun_out     = r_overrun;

endmodule

// File: tb/tb_read_out_sequencer.sv
// Bench for read_out_sequencer: main instance (2 banks x 4 words, latency 2, 3-entry FIFO)
// checked by a scoreboard monitor, plus a minimal 1x1 instance checked directly.
module tb_read_out_sequencer;
    localparam int AW = 8;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_err;
    int n_strobe;
    int n_acc;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;
    exp_t exp_q[$];

    read_out_sequencer_if #(.D_WIDTH(64), .ADDR_WIDTH(AW), .BANK_W(1)) a_if ();
    read_out_sequencer_if #(.D_WIDTH(64), .ADDR_WIDTH(AW), .BANK_W(1)) b_if ();

    read_out_sequencer #(
        .D_WIDTH(64), .ADDR_WIDTH(AW), .NUM_BANKS(2), .BURST_LEN(4),
        .RD_LATENCY(2), .FIFO_DEPTH(3)
    ) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (a_if)
    );

    read_out_sequencer #(
        .D_WIDTH(64), .ADDR_WIDTH(AW), .NUM_BANKS(1), .BURST_LEN(1),
        .RD_LATENCY(1), .FIFO_DEPTH(2)
    ) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (b_if)
    );

    function automatic logic [63:0] word_of(input int b, input int a);
        return 64'hC0DE_0000_0000_0000 | (64'(b) << 16) | 64'(a);
    endfunction

    // Result memory models: the addressed word appears RD_LATENCY cycles after the strobe.
    logic [63:0] a_pipe [2];
    logic [63:0] b_pipe;

    always @(posedge clk) begin
        a_pipe[0] <= a_if.res_rd_en_out ?
                     word_of(int'(a_if.res_rd_bank_out), int'(a_if.res_rd_addr_out)) :
                     64'hBAD0_BAD0_BAD0_BAD0;
        a_pipe[1] <= a_pipe[0];
        b_pipe    <= b_if.res_rd_en_out ?
                     word_of(int'(b_if.res_rd_bank_out), int'(b_if.res_rd_addr_out)) :
                     64'hBAD1_BAD1_BAD1_BAD1;
    end

    assign a_if.res_rd_data_in = a_pipe[1];
    assign b_if.res_rd_data_in = b_pipe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_job();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 4; a++) begin
                exp_q.push_back({word_of(b, a), (b == 1 && a == 3)});
            end
        end
    endtask

    task automatic wait_done_a(input int max, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            @(negedge clk);
            if (a_if.done_out) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd1);
        chk({name, "_busy_idle"}, 64'(a_if.busy_out), 64'd0);
    endtask

    // Monitor: read order, stream hold rules, done timing and scoreboard pop/compare.
    initial begin
        int   s_bank;
        int   s_addr;
        bit   prev_stall;
        bit   prev_last_acc;
        logic [63:0] prev_data;
        exp_t e;
        s_bank = 0; s_addr = 0; prev_stall = 0; prev_last_acc = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                s_bank = 0; s_addr = 0; prev_stall = 0; prev_last_acc = 0;
            end else begin
                if (a_if.res_rd_en_out) begin
                    n_strobe++;
                    chk("strobe_bank", 64'(a_if.res_rd_bank_out), 64'(s_bank));
                    chk("strobe_addr", 64'(a_if.res_rd_addr_out), 64'(s_addr));
                    if (s_addr == 3) begin
                        s_addr = 0;
                        s_bank = (s_bank == 1) ? 0 : s_bank + 1;
                    end else begin
                        s_addr++;
                    end
                end
                if (prev_stall) begin
                    chk("hold_valid", 64'(a_if.out_valid), 64'd1);
                    chk("hold_data", a_if.out_data, prev_data);
                end
                if (prev_last_acc || a_if.done_out) begin
                    chk("done_pulse", 64'(a_if.done_out), 64'(prev_last_acc));
                end
                if (a_if.out_valid && a_if.out_ready) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", a_if.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", a_if.out_data, e.d);
                        chk("word_last", 64'(a_if.out_last), 64'(e.l));
                    end
                end
                prev_stall    = a_if.out_valid && !a_if.out_ready;
                prev_data     = a_if.out_data;
                prev_last_acc = a_if.out_valid && a_if.out_ready && a_if.out_last;
            end
        end
    end

    // Stimulus.
    initial begin
        int s_acc;
        int s_str;
        int b_busy;
        int b_done;
        int b_words;
        bit seen;
        n_chk = 0; n_err = 0; n_strobe = 0; n_acc = 0;
        rst_n = 1'b0;
        a_if.output_trigger_in = 1'b0;
        a_if.out_ready = 1'b0;
        b_if.output_trigger_in = 1'b0;
        b_if.out_ready = 1'b1;

        // Reset: outputs quiet; a trigger change while in reset is not a request.
        tick(2);
        a_if.output_trigger_in = 1'b1;
        tick(2);
        chk("reset_ctrl", {58'd0, a_if.busy_out, a_if.done_out, a_if.overrun_out,
                           a_if.out_valid, a_if.out_last, a_if.res_rd_en_out}, 64'd0);
        chk("reset_addr_bank", {55'd0, a_if.res_rd_bank_out, a_if.res_rd_addr_out}, 64'd0);
        chk("reset_data", a_if.out_data, 64'd0);
        rst_n = 1'b1;
        tick(5);
        chk("no_edge_after_reset", 64'(a_if.busy_out), 64'd0);

        // Job with ready held high.
        a_if.out_ready = 1'b1;
        s_acc = n_acc; s_str = n_strobe;
        a_if.output_trigger_in = ~a_if.output_trigger_in;
        push_job();
        @(negedge clk);
        chk("busy_edge_cycle", 64'(a_if.busy_out), 64'd0);
        @(negedge clk);
        chk("busy_after_edge", 64'(a_if.busy_out), 64'd1);
        wait_done_a(80, "done_basic");
        chk("words_basic", 64'(n_acc - s_acc), 64'd8);
        chk("strobes_basic", 64'(n_strobe - s_str), 64'd8);

        // Backpressure: only FIFO_DEPTH strobes while ready is low.
        tick(1);
        a_if.out_ready = 1'b0;
        s_acc = n_acc; s_str = n_strobe;
        a_if.output_trigger_in = ~a_if.output_trigger_in;
        push_job();
        tick(20);
        chk("stall_strobes", 64'(n_strobe - s_str), 64'd3);
        chk("stall_valid", 64'(a_if.out_valid), 64'd1);
        a_if.out_ready = 1'b1;
        wait_done_a(80, "done_stall");
        chk("words_stall", 64'(n_acc - s_acc), 64'd8);
        chk("strobes_stall", 64'(n_strobe - s_str), 64'd8);

        // Random ready.
        tick(1);
        s_acc = n_acc;
        a_if.output_trigger_in = ~a_if.output_trigger_in;
        push_job();
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk);
            #1;
            a_if.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (a_if.done_out) seen = 1'b1;
        end
        chk("done_random", 64'(seen), 64'd1);
        chk("words_random", 64'(n_acc - s_acc), 64'd8);
        chk("overrun_before_double", 64'(a_if.overrun_out), 64'd0);

        // Two toggles three cycles apart.
        a_if.out_ready = 1'b1;
        tick(1);
        s_acc = n_acc;
        a_if.output_trigger_in = ~a_if.output_trigger_in;
        push_job();
        tick(3);
        a_if.output_trigger_in = ~a_if.output_trigger_in;
`ifdef READ_OUT_SEQ_PENDING_EN
        push_job();
        wait_done_a(80, "done_double_1");
        wait_done_a(80, "done_double_2");
        tick(20);
        chk("words_double", 64'(n_acc - s_acc), 64'd16);
        chk("overrun_double", 64'(a_if.overrun_out), 64'd0);
`else
        wait_done_a(80, "done_double");
        tick(20);
        chk("words_double", 64'(n_acc - s_acc), 64'd8);
        chk("overrun_double", 64'(a_if.overrun_out), 64'd1);
`endif
        chk("idle_after_double", 64'(a_if.busy_out), 64'd0);

        // Reset in the middle of a job, after the fifth word.
        s_acc = n_acc;
        a_if.output_trigger_in = ~a_if.output_trigger_in;
        push_job();
        for (int k = 0; k < 100 && (n_acc - s_acc) < 5; k++) tick(1);
        chk("words_before_reset", 64'(n_acc - s_acc), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("midjob_reset_ctrl", {58'd0, a_if.busy_out, a_if.done_out, a_if.overrun_out,
                                  a_if.out_valid, a_if.out_last, a_if.res_rd_en_out}, 64'd0);
        chk("midjob_reset_addr", {55'd0, a_if.res_rd_bank_out, a_if.res_rd_addr_out}, 64'd0);
        chk("midjob_reset_data", a_if.out_data, 64'd0);
        tick(3);
        rst_n = 1'b1;
        s_acc = n_acc;
        tick(10);
        chk("no_stale_words", 64'(n_acc - s_acc), 64'd0);
        chk("idle_after_reset", 64'(a_if.busy_out), 64'd0);
        a_if.output_trigger_in = ~a_if.output_trigger_in;
        push_job();
        wait_done_a(80, "done_after_reset");
        chk("words_after_reset", 64'(n_acc - s_acc), 64'd8);

        // Minimal configuration: one word, latency 1.
        tick(1);
        b_busy = 0; b_done = 0; b_words = 0;
        b_if.output_trigger_in = ~b_if.output_trigger_in;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b_if.busy_out) b_busy++;
            if (b_if.done_out) b_done++;
            if (b_if.out_valid && b_if.out_ready) begin
                b_words++;
                chk("min_data", b_if.out_data, word_of(0, 0));
                chk("min_last", 64'(b_if.out_last), 64'd1);
            end
        end
        chk("min_words", 64'(b_words), 64'd1);
        chk("min_busy_cycles", 64'(b_busy), 64'd3);
        chk("min_done_pulses", 64'(b_done), 64'd1);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
